// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse digit sequencer.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPT,
        MARK,
        SPACE,
        GAP
    } state_t;

    localparam logic [1:0] DOT_UNITS   = 2'd1;
    localparam logic [1:0] DASH_UNITS  = 2'd3;
    localparam logic [1:0] SPACE_UNITS = 2'd1;
    localparam logic [1:0] GAP_UNITS   = 2'd3;
    localparam int         SYMBOLS     = 5;

    localparam logic SYM_DOT  = 1'b1;
    localparam logic SYM_DASH = 1'b0;

    function automatic logic [1:0] mark_units(input logic sym);
        return (sym == SYM_DOT) ? DOT_UNITS : DASH_UNITS;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Unit timer: a prescaler of UNIT_CYCLES clocks feeding a down-counter of Morse units.
module morse_unit_timer
#(
    parameter int UNIT_CYCLES = 4
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [1:0] units,
    output logic       expire,
    output logic       expire_next
);

    localparam int            PW        = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(UNIT_CYCLES - 1);

    logic [PW-1:0] presc;
    logic [1:0]    left;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            left  <= 2'd0;
        end else if (load) begin
            presc <= PRESC_TOP;
            left  <= units - 2'd1;
        end else if (presc == '0) begin
            presc <= PRESC_TOP;
            if (left != 2'd0)
                left <= left - 2'd1;
        end else begin
            presc <= presc - PW'(1);
        end
    end

    assign expire = (presc == '0) && (left == 2'd0);

    // expire_next flags the cycle before expire so callers can register a last-cycle pulse
    generate
        if (UNIT_CYCLES == 1) begin : g_single
            assign expire_next = (left == 2'd1);
        end else begin : g_multi
            assign expire_next = (left == 2'd0) && (presc == PW'(1));
        end
    endgenerate

endmodule

// File: rtl/morse_sequenciador.sv
// Morse digit sequencer: loads codifMorse, keys out its 5-symbol code with dot/dash timing.
// Optional one-entry pending digit register enabled by MORSE_PENDING_EN.
module morse_sequenciador
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] num,
    input  logic       ready,
    output logic       ack,
    output logic       busy,
    output logic [3:0] enc_num,
    output logic       enc_ready,
    input  logic [4:0] enc_morse,
    output logic       key,
    output logic       ponto,
    output logic       traco,
    output logic       done,
    output logic       err
);

    state_t     state;
    logic [4:0] shreg;
    logic [2:0] idx;
    logic       tmr_load;
    logic [1:0] tmr_units;
    logic       expire;
    logic       expire_next;
    logic       accept;
    logic       digit_ok;

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .load        (tmr_load),
        .units       (tmr_units),
        .expire      (expire),
        .expire_next (expire_next)
    );

`ifdef MORSE_PENDING_EN
    logic [3:0] pend;
    logic       pend_vld;

    // Blocking the cycle before done keeps an err pulse from landing on the done cycle
    assign ack = reset && !pend_vld && !((state == GAP) && expire_next);
`else
    assign ack = reset && (state == IDLE);
`endif

    assign accept   = ready && ack;
    assign digit_ok = (num <= 4'd9);

    always_comb begin
        tmr_load  = 1'b0;
        tmr_units = SPACE_UNITS;
        case (state)
            CAPT: begin
                tmr_load  = 1'b1;
                tmr_units = mark_units(enc_morse[4]);
            end
            MARK: begin
                tmr_load  = expire;
                tmr_units = (idx == 3'(SYMBOLS - 1)) ? GAP_UNITS : SPACE_UNITS;
            end
            SPACE: begin
                tmr_load  = expire;
                tmr_units = mark_units(shreg[4]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == CAPT)
            shreg <= enc_morse;
        else if ((state == MARK) && expire)
            shreg <= {shreg[3:0], 1'b0};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= 3'd0;
            busy      <= 1'b0;
            enc_num   <= 4'd0;
            enc_ready <= 1'b0;
            key       <= 1'b0;
            ponto     <= 1'b0;
            traco     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            enc_ready <= 1'b0;
            done      <= 1'b0;
            err       <= accept && !digit_ok;
            case (state)
                IDLE: begin
                    if (accept && digit_ok) begin
                        state     <= LOAD;
                        enc_num   <= num;
                        enc_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD: state <= CAPT;
                CAPT: begin
                    state <= MARK;
                    idx   <= 3'd0;
                    key   <= 1'b1;
                    ponto <= (enc_morse[4] == SYM_DOT);
                    traco <= (enc_morse[4] == SYM_DASH);
                end
                MARK: begin
                    if (expire) begin
                        key   <= 1'b0;
                        ponto <= 1'b0;
                        traco <= 1'b0;
                        if (idx == 3'(SYMBOLS - 1)) begin
                            state <= GAP;
                        end else begin
                            state <= SPACE;
                            idx   <= idx + 3'd1;
                        end
                    end
                end
                SPACE: begin
                    if (expire) begin
                        state <= MARK;
                        key   <= 1'b1;
                        ponto <= (shreg[4] == SYM_DOT);
                        traco <= (shreg[4] == SYM_DASH);
                    end
                end
                GAP: begin
                    done <= expire_next;
                    if (expire) begin
`ifdef MORSE_PENDING_EN
                        if (pend_vld) begin
                            state     <= LOAD;
                            enc_num   <= pend;
                            enc_ready <= 1'b1;
                        end else if (accept && digit_ok) begin
                            state     <= LOAD;
                            enc_num   <= num;
                            enc_ready <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MORSE_PENDING_EN
    always_ff @(posedge clk) begin
        if (accept && digit_ok)
            pend <= num;
    end

    // The slot only holds digits that arrive mid-playback; IDLE and last-GAP accepts load directly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pend_vld <= 1'b0;
        else if ((state == GAP) && expire && pend_vld)
            pend_vld <= 1'b0;
        else if (accept && digit_ok && (state != IDLE) && !((state == GAP) && expire))
            pend_vld <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_morse_sequenciador.sv
// Scoreboard bench for morse_sequenciador with a behavioural codifMorse stand-in.
module tb_morse_sequenciador;

    localparam int U = 2;
    localparam int K_LOAD = 0;
    localparam int K_DOT  = 1;
    localparam int K_DASH = 2;
    localparam int K_DONE = 3;
    localparam int K_ERR  = 4;
`ifdef MORSE_PENDING_EN
    localparam int HANDOFF = 2;
`else
    localparam int HANDOFF = 3;
`endif

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] num;
    logic       ready;
    logic       ack;
    logic       busy;
    logic [3:0] enc_num;
    logic       enc_ready;
    logic [4:0] enc_morse = 5'd0;
    logic       key;
    logic       ponto;
    logic       traco;
    logic       done;
    logic       err;

    ev_t exp_q[$];
    int  done_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  run      = 0;
    int  load_cyc = 0;
    logic was_dot = 1'b0;

    always #5 clk = ~clk;

    morse_sequenciador #(.UNIT_CYCLES(U)) dut (
        .clk       (clk),
        .reset     (reset),
        .num       (num),
        .ready     (ready),
        .ack       (ack),
        .busy      (busy),
        .enc_num   (enc_num),
        .enc_ready (enc_ready),
        .enc_morse (enc_morse),
        .key       (key),
        .ponto     (ponto),
        .traco     (traco),
        .done      (done),
        .err       (err)
    );

    function automatic logic [4:0] code_of(input int d);
        case (d)
            0:       return 5'b00000;
            1:       return 5'b10000;
            2:       return 5'b11000;
            3:       return 5'b11100;
            4:       return 5'b11110;
            5:       return 5'b11111;
            6:       return 5'b01111;
            7:       return 5'b00111;
            8:       return 5'b00011;
            default: return 5'b00001;
        endcase
    endfunction

    function automatic int units_of(input int d);
        logic [4:0] c;
        int n;
        c = code_of(d);
        n = 7;
        for (int i = 0; i < 5; i++) n += c[i] ? 1 : 3 + 1 - 1;
        return n;
    endfunction

    // Encoder stand-in: result ready the cycle after the load strobe
    always @(posedge clk) if (enc_ready) enc_morse <= code_of(int'(enc_num));

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_ev(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic push_digit(input int d);
        logic [4:0] c;
        c = code_of(d);
        push_ev(K_LOAD, d);
        for (int i = 4; i >= 0; i--) push_ev(c[i] ? K_DOT : K_DASH, c[i] ? U : 3 * U);
        push_ev(K_DONE, 1 + units_of(d) * U);
    endtask

    task automatic sb_check(input int k, input int v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected actual kind=%0d val=%0d required none", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                failures++;
                $display("FAIL sb_event actual kind=%0d val=%0d required kind=%0d val=%0d",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    // Monitor: turns DUT activity into events and compares them against the queue
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                run = 0;
            end else begin
                if (enc_ready) begin
                    sb_check(K_LOAD, int'(enc_num));
                    load_cyc = cyc;
                end
                if (key) begin
                    check_eq("mark_onehot", int'(ponto) + int'(traco), 1);
                    run++;
                    was_dot = ponto;
                end else begin
                    check_eq("space_quiet", int'(ponto | traco), 0);
                    if (run > 0) begin
                        sb_check(was_dot ? K_DOT : K_DASH, run);
                        run = 0;
                    end
                end
                if (done) begin
                    sb_check(K_DONE, cyc - load_cyc);
                    done_q.push_back(cyc);
                end
                if (err) sb_check(K_ERR, 0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input int d);
        int got;
        if (d <= 9) push_digit(d);
        else        push_ev(K_ERR, 0);
        num   = 4'(d);
        ready = 1'b1;
        got   = 0;
        for (int i = 0; i < 300; i++) begin
            if (ack) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("ack_seen", got, 1);
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check_eq("done_seen", seen, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int ack_bad;
        int seen;
        int dones;
        reset = 1'b0;
        ready = 1'b0;
        num   = 4'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_key", int'(key), 0);
        check_eq("rst_ponto", int'(ponto), 0);
        check_eq("rst_traco", int'(traco), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_err", int'(err), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_enc_ready", int'(enc_ready), 0);
        check_eq("rst_enc_num", int'(enc_num), 0);
        check_eq("rst_ack", int'(ack), 0);
        reset = 1'b1;
        #1 check_eq("ack_after_release", int'(ack), 1);
        @(negedge clk);

        // Digit 1 with latency checks: LOAD, CAPT, then first mark
        send(1);
        check_eq("d1_load_strobe", int'(enc_ready), 1);
        check_eq("d1_load_busy", int'(busy), 1);
        check_eq("d1_enc_num", int'(enc_num), 1);
        @(negedge clk);
        check_eq("d1_capt_key", int'(key), 0);
        @(negedge clk);
        check_eq("d1_first_key", int'(key), 1);
        check_eq("d1_first_ponto", int'(ponto), 1);
        wait_done(200);
        @(negedge clk);
        check_eq("d1_idle_busy", int'(busy), 0);
        check_eq("d1_idle_ack", int'(ack), 1);

        // Out-of-range digit is dropped with err
        send(12);
        check_eq("err_busy", int'(busy), 0);
        check_eq("err_no_load", int'(enc_ready), 0);
        repeat (3) begin
            @(negedge clk);
            check_eq("err_busy_stays", int'(busy), 0);
        end

`ifdef MORSE_PENDING_EN
        send(5);
        send(0);
        check_eq("pend_accept_busy", int'(busy), 1);
        wait_done(200);
        @(negedge clk);
        check_eq("pend_direct_load", int'(enc_ready), 1);
        check_eq("pend_enc_num", int'(enc_num), 0);
        wait_done(200);
        @(negedge clk);
`else
        send(3);
        num     = 4'd7;
        ready   = 1'b1;
        ack_bad = 0;
        seen    = 0;
        for (int i = 0; i < 300; i++) begin
            if (ack) ack_bad++;
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("held_done_seen", seen, 1);
        check_eq("held_ack_low", ack_bad, 0);
        push_digit(7);
        @(negedge clk);
        check_eq("held_idle_ack", int'(ack), 1);
        @(negedge clk);
        check_eq("held_load", int'(enc_ready), 1);
        check_eq("held_enc_num", int'(enc_num), 7);
        ready = 1'b0;
        wait_done(200);
        @(negedge clk);
`endif

        // Reset in the middle of the first dash of digit 0
        send(0);
        repeat (4) @(negedge clk);
        check_eq("dash_key", int'(key), 1);
        check_eq("dash_traco", int'(traco), 1);
        #2 reset = 1'b0;
        exp_q.delete();
        #1;
        check_eq("arst_key", int'(key), 0);
        check_eq("arst_traco", int'(traco), 0);
        check_eq("arst_busy", int'(busy), 0);
        check_eq("arst_ack", int'(ack), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 check_eq("arst_release_ack", int'(ack), 1);
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("arst_no_done", dones, 0);
        check_eq("arst_idle_busy", int'(busy), 0);

        // All digits back-to-back; done spacing follows the unit formula
        done_q.delete();
        for (int d = 0; d < 10; d++) send(d);
        seen = 0;
        for (int i = 0; i < 600; i++) begin
            if (done_q.size() >= 10) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("b2b_all_done", seen, 1);
        if (done_q.size() >= 10) begin
            for (int k = 1; k < 10; k++)
                check_eq($sformatf("b2b_spacing_%0d", k), done_q[k] - done_q[k-1],
                         HANDOFF + units_of(k) * U);
        end
        repeat (4) @(negedge clk);
        check_eq("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
